// File: rtl/wasm_host_loader_pkg.sv
// Shared types and constants for the host-side program loader.
package wasm_host_loader_pkg;

  localparam logic [1:0] WORK_DONE = 2'b11;
  localparam int         INSTR_W   = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_PACK,
    ST_WRITE,
    ST_FIN,
    ST_WAIT,
    ST_DUMP_RD,
    ST_DUMP_TX,
    ST_END
  } ld_state_e;

  // Busy covers every phase of a load/dump session.
  function automatic logic is_busy(ld_state_e s);
    return (s != ST_IDLE) && (s != ST_END);
  endfunction

endpackage

// File: rtl/wasm_host_loader_if.sv
// Core-side bus of the loader: instruction-memory write port, finish flag,
// core status and the line-memory read port.
interface wasm_host_loader_if #(
  parameter int IMEM_AW = 15,
  parameter int LINE_AW = 9
);
  import wasm_host_loader_pkg::*;

  logic                  o_instr_mem_wr_vld;
  logic [IMEM_AW-1:0]    o_instr_mem_wr_addr;
  logic [INSTR_W-1:0]    o_instr_mem_wr_data;
  logic                  i_instr_mem_wr_rdy;
  logic                  o_instr_mem_wr_finish;
  logic [1:0]            i_work_state;
  logic [2:0]            i_core_error;
  logic                  o_line_mem_rd_rdy;
  logic [LINE_AW-1:0]    o_line_mem_rd_addr;
  logic [31:0]           i_line_mem_rd_data;

  modport master (
    output o_instr_mem_wr_vld, o_instr_mem_wr_addr, o_instr_mem_wr_data,
    output o_instr_mem_wr_finish, o_line_mem_rd_rdy, o_line_mem_rd_addr,
    input  i_instr_mem_wr_rdy, i_work_state, i_core_error, i_line_mem_rd_data
  );

  modport slave (
    input  o_instr_mem_wr_vld, o_instr_mem_wr_addr, o_instr_mem_wr_data,
    input  o_instr_mem_wr_finish, o_line_mem_rd_rdy, o_line_mem_rd_addr,
    output i_instr_mem_wr_rdy, i_work_state, i_core_error, i_line_mem_rd_data
  );

endinterface

// File: rtl/wasm_host_loader_packer.sv
// Collects eight bytes into one 64-bit instruction word, byte 0 in [7:0].
module wasm_host_loader_packer
  import wasm_host_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         byte_in,
  input  logic               clr,
  output logic [INSTR_W-1:0] data,
  output logic               full,
  output logic               fill
);

  logic [2:0]         cnt_q, cnt_d;
  logic               full_q, full_d;
  logic [INSTR_W-1:0] data_q, data_d;

  // Each lane loads only when the byte counter points at it.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign data_d[8*gi +: 8] = (push && (cnt_q == 3'(gi))) ? byte_in : data_q[8*gi +: 8];
  end

  // The eighth byte fills the word; the counter wraps to 0 ready for the next one.
  always_comb begin
    fill   = push && (cnt_q == 3'd7);
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr) begin
      cnt_d  = 3'd0;
      full_d = 1'b0;
    end else if (push) begin
      cnt_d  = cnt_q + 3'd1;
      full_d = fill;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/wasm_host_loader.sv
// Host loader: byte stream -> instruction memory, then line-memory dump -> byte stream.
module wasm_host_loader
  import wasm_host_loader_pkg::*;
#(
  parameter int               IMEM_AW = 15,
  parameter int               LINE_AW = 9,
  parameter logic [LINE_AW-1:0] RD_BASE = 'h100,
  parameter int unsigned      RD_CNT  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_byte_vld,
  input  logic [7:0]          s_byte_data,
  output logic                s_byte_rdy,
  output logic                m_byte_vld,
  output logic [7:0]          m_byte_data,
  input  logic                m_byte_rdy,
  output logic                o_busy,
  output logic [1:0]          o_err,
  wasm_host_loader_if.master  core
);

  localparam int          CNT_W      = LINE_AW + 1;
  localparam logic [31:0] IMEM_DEPTH = 32'd1 << IMEM_AW;

  ld_state_e          state_q, state_d;
  logic [7:0]         hdr_lo_q, hdr_lo_d;
  logic [15:0]        n_q, n_d, words_q, words_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               wr_vld_q, wr_vld_d, finish_q, finish_d;
  logic               s_rdy_q, s_rdy_d, busy_q, busy_d, rd_rdy_q, rd_rdy_d;
  logic [LINE_AW-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]   dump_cnt_q, dump_cnt_d;
  logic [1:0]         tx_idx_q, tx_idx_d;
  logic               tx_first_q, tx_first_d, m_vld_q, m_vld_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         err_q, err_d;

  logic               s_acc, m_acc, pk_push, pk_clr, pk_full, pk_fill, word_ovf, fault;
  logic [INSTR_W-1:0] pk_data;
  logic [15:0]        words_inc;
  logic [31:0]        tx_word;

  assign s_acc     = s_byte_vld && s_rdy_q;
  assign m_acc     = m_vld_q && m_byte_rdy;
  assign pk_push   = s_acc && (state_q == ST_PACK);
  assign words_inc = words_q + 16'd1;
  assign word_ovf  = {16'd0, words_q} >= IMEM_DEPTH;
  assign fault     = core.i_core_error != 3'd0;

  wasm_host_loader_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (pk_push),
    .byte_in (s_byte_data),
    .clr     (pk_clr),
    .data    (pk_data),
    .full    (pk_full),
    .fill    (pk_fill)
  );

  // Next-state and next-output logic for the whole load/dump sequence.
  always_comb begin
    state_d    = state_q;    hdr_lo_d   = hdr_lo_q;   n_d      = n_q;
    words_d    = words_q;    addr_d     = addr_q;     wr_vld_d = wr_vld_q;
    rd_addr_d  = rd_addr_q;  dump_cnt_d = dump_cnt_q; tx_idx_d = tx_idx_q;
    tx_first_d = tx_first_q; m_vld_d    = m_vld_q;    word_d   = word_q;
    err_d      = err_q;      pk_clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (s_acc) begin
        hdr_lo_d = s_byte_data;
        state_d  = ST_HDR;
      end
      ST_HDR: if (s_acc) begin
        n_d     = {s_byte_data, hdr_lo_q};
        state_d = ({s_byte_data, hdr_lo_q} == 16'd0) ? ST_FIN : ST_PACK;
      end
      ST_PACK: if (pk_fill) begin
        // Words beyond the memory are consumed but never offered to the core.
        state_d  = ST_WRITE;
        wr_vld_d = !word_ovf;
      end
      ST_WRITE: begin
        if (!wr_vld_q) begin
          err_d[0] = 1'b1;
          words_d  = words_inc;
          pk_clr   = 1'b1;
          state_d  = (words_inc == n_q) ? ST_FIN : ST_PACK;
        end else if (pk_full && core.i_instr_mem_wr_rdy) begin
          wr_vld_d = 1'b0;
          words_d  = words_inc;
          if (addr_q != '1) addr_d = addr_q + 1'b1;
          pk_clr   = 1'b1;
          state_d  = (words_inc == n_q) ? ST_FIN : ST_PACK;
        end
      end
      ST_FIN: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fault) begin
          err_d[1] = 1'b1;
          state_d  = ST_END;
        end else if (core.i_work_state == WORK_DONE) begin
          rd_addr_d  = RD_BASE;
          dump_cnt_d = '0;
          state_d    = ST_DUMP_RD;
        end
      end
      ST_DUMP_RD: begin
        if (fault) begin
          err_d[1] = 1'b1;
          state_d  = ST_END;
        end else begin
          state_d    = ST_DUMP_TX;
          m_vld_d    = 1'b1;
          tx_idx_d   = 2'd0;
          tx_first_d = 1'b1;
        end
      end
      ST_DUMP_TX: begin
        if (fault) begin
          err_d[1] = 1'b1;
          m_vld_d  = 1'b0;
          state_d  = ST_END;
        end else begin
          // Read data is live only in the first transmit cycle, so capture it there.
          if (tx_first_q) word_d = core.i_line_mem_rd_data;
          tx_first_d = 1'b0;
          if (m_acc) begin
            tx_idx_d = tx_idx_q + 2'd1;
            if (tx_idx_q == 2'd3) begin
              m_vld_d = 1'b0;
              if ((dump_cnt_q + 1'b1) == CNT_W'(RD_CNT)) begin
                state_d = ST_END;
              end else begin
                dump_cnt_d = dump_cnt_q + 1'b1;
                rd_addr_d  = rd_addr_q + 1'b1;
                state_d    = ST_DUMP_RD;
              end
            end
          end
        end
      end
      default: ;
    endcase
    s_rdy_d  = (state_d == ST_IDLE) || (state_d == ST_HDR) || (state_d == ST_PACK);
    finish_d = finish_q || (state_d == ST_FIN);
    busy_d   = is_busy(state_d);
    rd_rdy_d = (state_d == ST_DUMP_RD) || (state_d == ST_DUMP_TX);
  end

  // All FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE; hdr_lo_q   <= '0;  n_q      <= '0;   words_q  <= '0;
      addr_q   <= '0;      wr_vld_q   <= 1'b0; finish_q <= 1'b0; s_rdy_q  <= 1'b0;
      busy_q   <= 1'b0;    rd_rdy_q   <= 1'b0; rd_addr_q <= '0;  dump_cnt_q <= '0;
      tx_idx_q <= '0;      tx_first_q <= 1'b0; m_vld_q  <= 1'b0; word_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;  hdr_lo_q   <= hdr_lo_d;   n_q       <= n_d;       words_q    <= words_d;
      addr_q   <= addr_d;   wr_vld_q   <= wr_vld_d;   finish_q  <= finish_d;  s_rdy_q    <= s_rdy_d;
      busy_q   <= busy_d;   rd_rdy_q   <= rd_rdy_d;   rd_addr_q <= rd_addr_d; dump_cnt_q <= dump_cnt_d;
      tx_idx_q <= tx_idx_d; tx_first_q <= tx_first_d; m_vld_q   <= m_vld_d;   word_q     <= word_d;
      err_q    <= err_d;
    end
  end

  assign tx_word                    = tx_first_q ? core.i_line_mem_rd_data : word_q;
  assign m_byte_data                = tx_word[{tx_idx_q, 3'b000} +: 8];
  assign m_byte_vld                 = m_vld_q;
  assign s_byte_rdy                 = s_rdy_q;
  assign o_busy                     = busy_q;
  assign o_err                      = err_q;
  assign core.o_instr_mem_wr_vld    = wr_vld_q;
  assign core.o_instr_mem_wr_addr   = addr_q;
  assign core.o_instr_mem_wr_data   = pk_data;
  assign core.o_instr_mem_wr_finish = finish_q;
  assign core.o_line_mem_rd_rdy     = rd_rdy_q;
  assign core.o_line_mem_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_wasm_host_loader.sv
// Directed bench for wasm_host_loader: load, empty image, write stall,
// dump with output backpressure, core fault, overflow and mid-load reset.
module tb_wasm_host_loader;
  import wasm_host_loader_pkg::*;

  localparam int          IMEM_AW = 2;
  localparam int          LINE_AW = 9;
  localparam logic [8:0]  RD_BASE = 9'h100;
  localparam int unsigned RD_CNT  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_vld = 1'b0, s_rdy, m_vld, m_rdy = 1'b0, busy;
  logic [7:0] s_data = 8'h00, m_data;
  logic [1:0] err;

  wasm_host_loader_if #(.IMEM_AW(IMEM_AW), .LINE_AW(LINE_AW)) bus ();

  wasm_host_loader #(.IMEM_AW(IMEM_AW), .LINE_AW(LINE_AW), .RD_BASE(RD_BASE), .RD_CNT(RD_CNT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_byte_vld(s_vld), .s_byte_data(s_data), .s_byte_rdy(s_rdy),
    .m_byte_vld(m_vld), .m_byte_data(m_data), .m_byte_rdy(m_rdy),
    .o_busy(busy), .o_err(err), .core(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Line memory with one cycle of read latency; contents depend on the address.
  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {4'hC, 3'd0, a, 16'h5AA5};
  endfunction

  initial bus.i_line_mem_rd_data = 32'h0;
  always @(posedge clk) if (bus.o_line_mem_rd_rdy) bus.i_line_mem_rd_data <= mem_word(bus.o_line_mem_rd_addr);

  // Passive monitors, sampled mid-cycle.
  int         wr_n = 0, wr_vld_cycles = 0, rd_cycles = 0, m_n = 0;
  logic [1:0] wr_a_log [16];
  logic [63:0] wr_d_log [16];
  logic [7:0] m_log [16];
  logic       m_hold = 1'b0;
  logic [7:0] m_held = 8'h00;

  always @(negedge clk) begin
    if (bus.o_instr_mem_wr_vld) wr_vld_cycles++;
    if (bus.o_instr_mem_wr_vld && bus.i_instr_mem_wr_rdy) begin
      if (wr_n < 16) begin
        wr_a_log[wr_n] = bus.o_instr_mem_wr_addr;
        wr_d_log[wr_n] = bus.o_instr_mem_wr_data;
      end
      wr_n++;
    end
    if (bus.o_line_mem_rd_rdy) rd_cycles++;
    if (m_vld && m_hold) begin
      checks++;
      if (m_data !== m_held) begin
        errors++;
        $display("FAIL m_stable got=%h exp=%h", m_data, m_held);
      end
    end
    if (m_vld && m_rdy) begin
      if (m_n < 16) m_log[m_n] = m_data;
      m_n++;
    end
    m_hold = m_vld && !m_rdy;
    m_held = m_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; s_vld = 1'b0; s_data = 8'h00; m_rdy = 1'b0;
    bus.i_instr_mem_wr_rdy = 1'b0; bus.i_work_state = 2'b00; bus.i_core_error = 3'd0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_vld = 1'b1; s_data = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s_rdy) ok = 1'b1;
    end
    @(posedge clk); #1;
    s_vld = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_byte timeout byte=%h", b);
    end
  endtask

  task automatic wait_finish(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.o_instr_mem_wr_finish) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s finish timeout got=0 exp=1", name);
    end
    tick(1);
  endtask

  task automatic wait_idle_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        m_rdy = ~m_rdy;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s end timeout busy=1 exp=0", name);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.i_instr_mem_wr_rdy = 1'b0; bus.i_work_state = 2'b00; bus.i_core_error = 3'd0;
    tick(2);
    @(negedge clk);
    checks++;
    if ({s_rdy, bus.o_instr_mem_wr_vld, bus.o_instr_mem_wr_finish, bus.o_line_mem_rd_rdy, m_vld, busy, err} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0", {s_rdy, bus.o_instr_mem_wr_vld, bus.o_instr_mem_wr_finish, bus.o_line_mem_rd_rdy, m_vld, busy, err});
    end
    checks++;
    if ({bus.o_instr_mem_wr_addr, bus.o_instr_mem_wr_data, bus.o_line_mem_rd_addr, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_buses addr=%h data=%h rdaddr=%h mdata=%h exp=0", bus.o_instr_mem_wr_addr, bus.o_instr_mem_wr_data, bus.o_line_mem_rd_addr, m_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    checks++;
    if ({s_rdy, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_rdy got=%b exp=10", {s_rdy, busy});
    end
  endtask

  task automatic test_load;
    do_reset();
    bus.i_instr_mem_wr_rdy = 1'b1; wr_n = 0;
    send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    wait_finish("load");
    checks++;
    if (wr_n !== 2) begin errors++; $display("FAIL load_count got=%0d exp=2", wr_n); end
    checks++;
    if ({wr_a_log[0], wr_d_log[0]} !== {2'd0, 64'h0706050403020100}) begin
      errors++; $display("FAIL load_w0 got=%h/%h exp=0/0706050403020100", wr_a_log[0], wr_d_log[0]);
    end
    checks++;
    if ({wr_a_log[1], wr_d_log[1]} !== {2'd1, 64'h0F0E0D0C0B0A0908}) begin
      errors++; $display("FAIL load_w1 got=%h/%h exp=1/0F0E0D0C0B0A0908", wr_a_log[1], wr_d_log[1]);
    end
    tick(5);
    @(negedge clk);
    checks++;
    if ({bus.o_instr_mem_wr_finish, busy, err, s_rdy} !== 5'b11000) begin
      errors++; $display("FAIL load_hold got=%b exp=11000", {bus.o_instr_mem_wr_finish, busy, err, s_rdy});
    end
  endtask

  task automatic test_dump;
    logic [7:0] exp_b [8];
    exp_b = '{8'hA5, 8'h5A, 8'h00, 8'hC1, 8'hA5, 8'h5A, 8'h01, 8'hC1};
    @(posedge clk); #1;
    m_n = 0; m_rdy = 1'b0;
    bus.i_work_state = WORK_DONE;
    wait_idle_end("dump");
    checks++;
    if (m_n !== 8) begin errors++; $display("FAIL dump_count got=%0d exp=8", m_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_log[i] !== exp_b[i]) begin
        errors++; $display("FAIL dump_byte%0d got=%h exp=%h", i, m_log[i], exp_b[i]);
      end
    end
    tick(3);
    @(negedge clk);
    checks++;
    if ({m_vld, s_rdy, bus.o_line_mem_rd_rdy, bus.o_instr_mem_wr_finish, err} !== 6'b000100) begin
      errors++; $display("FAIL dump_end got=%b exp=000100", {m_vld, s_rdy, bus.o_line_mem_rd_rdy, bus.o_instr_mem_wr_finish, err});
    end
    @(posedge clk); #1;
    m_rdy = 1'b0; bus.i_work_state = 2'b00;
  endtask

  task automatic test_empty;
    do_reset();
    wr_vld_cycles = 0;
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    checks++;
    if (bus.o_instr_mem_wr_finish !== 1'b1) begin errors++; $display("FAIL empty_finish got=0 exp=1"); end
    tick(4);
    @(negedge clk);
    checks++;
    if (wr_vld_cycles !== 0 || bus.o_instr_mem_wr_finish !== 1'b1) begin
      errors++; $display("FAIL empty_nowrite vld_cycles=%0d finish=%b exp=0/1", wr_vld_cycles, bus.o_instr_mem_wr_finish);
    end
  endtask

  task automatic test_stall;
    do_reset();
    wr_n = 0;
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 17));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_instr_mem_wr_vld, bus.o_instr_mem_wr_addr, bus.o_instr_mem_wr_data, s_rdy} !== {1'b1, 2'd0, 64'h8877665544332211, 1'b0}) begin
        errors++; $display("FAIL stall_c%0d vld=%b addr=%h data=%h srdy=%b exp=1/0/8877665544332211/0", c, bus.o_instr_mem_wr_vld, bus.o_instr_mem_wr_addr, bus.o_instr_mem_wr_data, s_rdy);
      end
    end
    @(posedge clk); #1;
    bus.i_instr_mem_wr_rdy = 1'b1;
    wait_finish("stall");
    checks++;
    if (wr_n !== 1 || wr_d_log[0] !== 64'h8877665544332211) begin
      errors++; $display("FAIL stall_write count=%0d data=%h exp=1/8877665544332211", wr_n, wr_d_log[0]);
    end
  endtask

  task automatic test_core_error;
    do_reset();
    rd_cycles = 0; m_n = 0;
    send_byte(8'h00); send_byte(8'h00);
    tick(2);
    bus.i_core_error = 3'b010;
    wait_idle_end("fault");
    checks++;
    if ({err, bus.o_instr_mem_wr_finish} !== 3'b101 || rd_cycles !== 0 || m_n !== 0) begin
      errors++; $display("FAIL fault_end err=%b finish=%b rd_cycles=%0d bytes=%0d exp=10/1/0/0", err, bus.o_instr_mem_wr_finish, rd_cycles, m_n);
    end
    bus.i_core_error = 3'd0; m_rdy = 1'b0;
  endtask

  task automatic test_overflow;
    do_reset();
    bus.i_instr_mem_wr_rdy = 1'b1; wr_n = 0;
    send_byte(8'h05); send_byte(8'h00);
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 8; k++) send_byte(8'(w * 16 + 48 + k));
    wait_finish("ovf");
    @(negedge clk);
    checks++;
    if (wr_n !== 4 || err !== 2'b01) begin
      errors++; $display("FAIL ovf_count writes=%0d err=%b exp=4/01", wr_n, err);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_a_log[i] !== 2'(i)) begin errors++; $display("FAIL ovf_addr%0d got=%h exp=%h", i, wr_a_log[i], 2'(i)); end
    end
    checks++;
    if (wr_d_log[3] !== 64'h6766656463626160 || bus.o_instr_mem_wr_addr !== 2'd3) begin
      errors++; $display("FAIL ovf_last data=%h addr=%h exp=6766656463626160/3", wr_d_log[3], bus.o_instr_mem_wr_addr);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.i_instr_mem_wr_rdy = 1'b1;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_rdy, bus.o_instr_mem_wr_vld, bus.o_instr_mem_wr_finish, busy, err, bus.o_instr_mem_wr_data, bus.o_instr_mem_wr_addr} !== '0) begin
      errors++; $display("FAIL midrst_outputs srdy=%b vld=%b fin=%b busy=%b err=%b data=%h exp=0", s_rdy, bus.o_instr_mem_wr_vld, bus.o_instr_mem_wr_finish, busy, err, bus.o_instr_mem_wr_data);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    wr_n = 0;
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_finish("midrst");
    checks++;
    if (wr_n !== 1 || {wr_a_log[0], wr_d_log[0]} !== {2'd0, 64'h0807060504030201}) begin
      errors++; $display("FAIL midrst_restart count=%0d addr=%h data=%h exp=1/0/0807060504030201", wr_n, wr_a_log[0], wr_d_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_dump();
    test_empty();
    test_stall();
    test_core_error();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
